// File: rtl/des_buf_pkg.sv
// Shared word/block types and packing helpers for the 3DES host-side buffers.
// Blocks carry the first (oldest) word in bits [31:0].
package des_buf_pkg;

  localparam int WORD_W  = 32;
  localparam int BLOCK_W = 64;

  typedef logic [WORD_W-1:0]  word_t;
  typedef logic [BLOCK_W-1:0] block_t;

  function automatic block_t pack_block(input word_t lo, input word_t hi);
    return {hi, lo};
  endfunction

  function automatic word_t unpack_lo(input block_t blk);
    return blk[WORD_W-1:0];
  endfunction

  function automatic word_t unpack_hi(input block_t blk);
    return blk[BLOCK_W-1:WORD_W];
  endfunction

endpackage

// File: rtl/in_buffer.sv
// Packs 32-bit host words into 64-bit cipher blocks through a shift array.
// Build option IN_BUF_OVERFLOW_EN enables the sticky dropped-write flag.
module in_buffer
  import des_buf_pkg::*;
#(
  parameter int DEPTH_WORDS = 8,
  parameter int CNT_W       = $clog2(DEPTH_WORDS) + 1
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic [31:0]      data_in,
  input  logic             data_in_valid,
  input  logic             block_pop,
  input  logic             clear,
  output logic [63:0]      data_out,
  output logic             block_ready,
  output logic             full,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] TWO_C   = CNT_W'(2);

  word_t            buff      [DEPTH_WORDS];
  word_t            buff_next [DEPTH_WORDS];
  logic [CNT_W-1:0] count_next;
  logic [CNT_W-1:0] wr_idx;
  logic             pop_ok;
  logic             wr_ok;

`ifdef IN_BUF_OVERFLOW_EN
  logic ovf_q;
  logic ovf_next;
`endif

  // A same-cycle pop frees two slots first, so a write is accepted even when full.
  always_comb begin
    buff_next  = buff;
    count_next = count;
    pop_ok     = block_pop && (count >= TWO_C);
    wr_ok      = data_in_valid && ((count < DEPTH_C) || pop_ok);
    wr_idx     = pop_ok ? (count - TWO_C) : count;
`ifdef IN_BUF_OVERFLOW_EN
    ovf_next   = ovf_q;
`endif

    if (clear) begin
      count_next = '0;
`ifdef IN_BUF_OVERFLOW_EN
      ovf_next   = 1'b0;
`endif
    end else begin
      if (pop_ok) begin
        for (int i = 0; i < DEPTH_WORDS - 2; i++) begin
          buff_next[i] = buff[i+2];
        end
      end
      if (wr_ok) begin
        for (int i = 0; i < DEPTH_WORDS; i++) begin
          if (CNT_W'(i) == wr_idx) begin
            buff_next[i] = data_in;
          end
        end
      end
      count_next = count + (wr_ok ? CNT_W'(1) : '0) - (pop_ok ? TWO_C : '0);
`ifdef IN_BUF_OVERFLOW_EN
      if (data_in_valid && !wr_ok) begin
        ovf_next = 1'b1;
      end
`endif
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      count <= '0;
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        buff[i] <= '0;
      end
`ifdef IN_BUF_OVERFLOW_EN
      ovf_q <= 1'b0;
`endif
    end else begin
      count <= count_next;
      buff  <= buff_next;
`ifdef IN_BUF_OVERFLOW_EN
      ovf_q <= ovf_next;
`endif
    end
  end

  assign data_out    = pack_block(buff[0], buff[1]);
  assign block_ready = (count >= TWO_C);
  assign full        = (count == DEPTH_C);

`ifdef IN_BUF_OVERFLOW_EN
  assign overflow = ovf_q;
`else
  assign overflow = 1'b0;
`endif

endmodule
